// File: rtl/spi_burst_arbiter_pkg.sv
// Shared types and constants for the SPI burst arbiter slice.
package spi_arb_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        DONE
    } arb_state_t;

    // Index width that stays at least one bit wide for degenerate requester counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_burst_arbiter_if.sv
// Byte-level handshake between the burst arbiter and a single spi_master core.
interface spi_burst_arbiter_if;
    import spi_arb_pkg::*;

    logic                  spi_start;
    logic [SPI_BYTE_W-1:0] spi_tx_data;
    logic [SPI_BYTE_W-1:0] spi_rx_data;
    logic                  spi_ready;
    logic                  spi_done;

    modport master (
        output spi_start,
        output spi_tx_data,
        input  spi_rx_data,
        input  spi_ready,
        input  spi_done
    );

    modport slave (
        input  spi_start,
        input  spi_tx_data,
        output spi_rx_data,
        output spi_ready,
        output spi_done
    );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first set request after last_grant, wrapping around.
module spi_rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               any_req,
    output logic [IDX_W-1:0]   winner
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate back to the nearest so the nearest set bit wins.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (req[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

endmodule

// File: rtl/spi_burst_arbiter.sv
// Shares one spi_master core among NUM_REQ requesters, one multi-byte burst per grant,
// with round-robin selection at burst boundaries and a per-byte stall watchdog.
module spi_burst_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*LEN_W-1:0]      req_len,
    input  logic [NUM_REQ*SPI_BYTE_W-1:0] tx_data,
    input  logic [NUM_REQ-1:0]            tx_valid,
    output logic [NUM_REQ-1:0]            tx_ready,
    output logic [SPI_BYTE_W-1:0]         rx_data,
    output logic [NUM_REQ-1:0]            rx_valid,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          burst_done,
    output logic                          burst_err,
    output logic [$clog2(NUM_REQ)-1:0]    cs_sel,
    spi_burst_arbiter_if.master           spi
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 2);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      win_q;
    logic [IDX_W-1:0]      last_grant_q;
    logic [LEN_W-1:0]      len_q;
    logic [LEN_W-1:0]      byte_cnt_q;
    logic [TMO_W-1:0]      tmo_cnt_q;
    logic                  err_q;
    logic [SPI_BYTE_W-1:0] tx_byte_q;
    logic [SPI_BYTE_W-1:0] rx_byte_q;
    logic [NUM_REQ-1:0]    rx_valid_q;

    logic                  any_req;
    logic [IDX_W-1:0]      winner;
    logic                  sel_req;
    logic                  accept;
    logic                  last_byte;
    logic                  timeout;

    logic [SPI_BYTE_W-1:0] tx_bytes   [NUM_REQ];
    logic [LEN_W-1:0]      len_fields [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign tx_bytes[i]   = tx_data[i*SPI_BYTE_W +: SPI_BYTE_W];
        assign len_fields[i] = req_len[i*LEN_W +: LEN_W];
    end

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req),
        .last_grant (last_grant_q),
        .any_req    (any_req),
        .winner     (winner)
    );

    assign sel_req   = req[win_q];
    assign accept    = (state_q == LOAD) && sel_req && tx_valid[win_q] && spi.spi_ready;
    assign last_byte = (byte_cnt_q == len_q);
    // The counter is one behind the cycle count in WAIT, so the abort lands TIMEOUT_CYCLES after spi_start.
    assign timeout   = (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt        = '0;
        cs_sel     = '0;
        tx_ready   = '0;
        burst_done = 1'b0;
        burst_err  = 1'b0;

        unique case (state_q)
            IDLE:    if (any_req) state_d = LOAD;
            LOAD: begin
                if (!sel_req) begin
                    state_d = DONE;
                end else if (accept) begin
                    state_d = START;
                end
            end
            START:   state_d = WAIT;
            WAIT: begin
                if (spi.spi_done) begin
                    state_d = last_byte ? DONE : LOAD;
                end else if (timeout) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d    = IDLE;
                burst_done = 1'b1;
                burst_err  = err_q;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            gnt[win_q] = 1'b1;
            cs_sel     = win_q;
        end
        if (accept) begin
            tx_ready[win_q] = 1'b1;
        end
    end

    // Burst datapath: winner/length latch, byte and watchdog counters, tx/rx byte registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q        <= '0;
            last_grant_q <= LAST_INIT;
            len_q        <= '0;
            byte_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            err_q        <= 1'b0;
            tx_byte_q    <= '0;
            rx_byte_q    <= '0;
            rx_valid_q   <= '0;
        end else begin
            rx_valid_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        win_q      <= winner;
                        len_q      <= len_fields[winner];
                        byte_cnt_q <= '0;
                        err_q      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) tx_byte_q <= tx_bytes[win_q];
                end
                START: tmo_cnt_q <= '0;
                WAIT: begin
                    if (tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    if (spi.spi_done) begin
                        rx_byte_q         <= spi.spi_rx_data;
                        rx_valid_q[win_q] <= 1'b1;
                        if (!last_byte) byte_cnt_q <= byte_cnt_q + LEN_W'(1);
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end
                end
                DONE: last_grant_q <= win_q;
                default: ;
            endcase
        end
    end

    assign rx_data         = rx_byte_q;
    assign rx_valid        = rx_valid_q;
    assign spi.spi_start   = (state_q == START);
    assign spi.spi_tx_data = tx_byte_q;

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Directed bench for spi_burst_arbiter with a small spi core model and per-requester byte feeders.
module tb_spi_burst_arbiter;
    import spi_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_len = '0;
    logic [31:0] tx_data;
    logic [3:0]  tx_valid = '0;
    logic [3:0]  tx_ready;
    logic [7:0]  rx_data;
    logic [3:0]  rx_valid;
    logic [3:0]  gnt;
    logic        burst_done;
    logic        burst_err;
    logic [1:0]  cs_sel;

    spi_burst_arbiter_if spi_bus ();

    spi_burst_arbiter #(
        .NUM_REQ        (4),
        .LEN_W          (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_len    (req_len),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .gnt        (gnt),
        .burst_done (burst_done),
        .burst_err  (burst_err),
        .cs_sel     (cs_sel),
        .spi        (spi_bus.master)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] tx_mem [4][256];
    logic [8:0] ptr [4];
    logic [3:0] acc_pend = '0;
    logic [7:0] rx_xor = '0;
    logic       core_mute = 1'b0;

    int cyc = 0;
    int n_txr [4];
    int n_start = 0;
    int n_done = 0;
    int n_err = 0;
    int lat_bad = 0;
    int last_start_cyc = 0;
    int last_done_cyc = 0;
    logic       last_done_err = 1'b0;
    logic [3:0] last_done_gnt = '0;
    logic [3:0] gnt_after_done = '0;
    logic       prev_txr = 1'b0;
    logic       prev_spi_done = 1'b0;
    logic       prev_done = 1'b0;
    logic [3:0] prev_gnt = '0;
    logic [11:0] rx_log [$];
    logic [5:0]  grant_log [$];
    int          gap_log [$];

    // Core model: three WAIT cycles per byte, returns the sent byte xor rx_xor.
    logic       busy = 1'b0;
    int         dly = 0;
    logic [7:0] latched = '0;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            busy                = 1'b0;
            spi_bus.spi_done    = 1'b0;
            spi_bus.spi_ready   = 1'b1;
            spi_bus.spi_rx_data = '0;
        end else begin
            spi_bus.spi_done = 1'b0;
            if (busy) begin
                if (dly == 0) begin
                    spi_bus.spi_done    = 1'b1;
                    spi_bus.spi_rx_data = latched ^ rx_xor;
                    spi_bus.spi_ready   = 1'b1;
                    busy                = 1'b0;
                end else begin
                    dly = dly - 1;
                end
            end else if (spi_bus.spi_start && !core_mute) begin
                busy              = 1'b1;
                dly               = 2;
                latched           = spi_bus.spi_tx_data;
                spi_bus.spi_ready = 1'b0;
            end
        end
    end

    // Requester feeders: present the next byte of each burst after every accept.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (!req[i]) ptr[i] = '0;
            else if (acc_pend[i]) ptr[i] = ptr[i] + 9'd1;
            tx_data[i*8 +: 8] = tx_mem[i][ptr[i][7:0]];
        end
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        acc_pend = tx_ready;
        if (!reset) begin
            for (int i = 0; i < 4; i++) if (tx_ready[i]) n_txr[i] = n_txr[i] + 1;
            if (spi_bus.spi_start) begin
                n_start = n_start + 1;
                last_start_cyc = cyc;
                if (!prev_txr) lat_bad = lat_bad + 1;
            end else if (prev_txr) begin
                lat_bad = lat_bad + 1;
            end
            if (rx_valid != '0) begin
                rx_log.push_back({rx_valid, rx_data});
                if (!prev_spi_done) lat_bad = lat_bad + 1;
            end
            if (burst_err && !burst_done) lat_bad = lat_bad + 1;
            if (burst_done) begin
                n_done = n_done + 1;
                last_done_cyc = cyc;
                last_done_err = burst_err;
                last_done_gnt = gnt;
                if (burst_err) n_err = n_err + 1;
            end
            if (prev_done) gnt_after_done = gnt;
            if (gnt != '0 && prev_gnt == '0) begin
                grant_log.push_back({gnt, cs_sel});
                gap_log.push_back(cyc - last_done_cyc);
            end
        end
        prev_txr      = |tx_ready;
        prev_spi_done = spi_bus.spi_done;
        prev_done     = burst_done;
        prev_gnt      = gnt;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors = vectors + 1;
        assert (observed === expected)
        else begin
            miscompares = miscompares + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic on, input logic [7:0] len);
        req[idx]            = on;
        req_len[idx*8 +: 8] = len;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    function automatic int countOf(input int which);
        case (which)
            0:       return n_done;
            1:       return n_start;
            2:       return rx_log.size();
            default: return n_txr[3];
        endcase
    endfunction

    task automatic waitUntil(input int which, input int target, input int budget, input string tag);
        int k = 0;
        while (countOf(which) < target && k < budget) begin
            step(1);
            k++;
        end
        checkOutput(tag, 32'(countOf(which)), 32'(target));
    endtask

    int b_start, b_rx, b_done, b_err, gb, bad;
    int b_txr [4];

    initial begin
        step(3);
        checkOutput("reset_gnt", 32'(gnt), 32'h0);
        checkOutput("reset_cs_sel", 32'(cs_sel), 32'h0);
        checkOutput("reset_misc", 32'({tx_ready, rx_valid, burst_done, burst_err, spi_bus.spi_start}), 32'h0);
        checkOutput("reset_bytes", 32'({spi_bus.spi_tx_data, rx_data}), 32'h0);
        checkOutput("reset_state", 32'(dut.state_q), 32'(IDLE));
        reset    = 1'b0;
        tx_valid = 4'hF;
        step(2);

        $display("[TB] single requester burst, len=2");
        tx_mem[0][0] = 8'hA5; tx_mem[0][1] = 8'h3C; tx_mem[0][2] = 8'hFF;
        rx_xor = 8'h00;
        b_start = n_start; b_rx = rx_log.size(); b_done = n_done;
        for (int i = 0; i < 4; i++) b_txr[i] = n_txr[i];
        applyStimulus(0, 1'b1, 8'd2);
        waitUntil(0, b_done + 1, 200, "t1_done");
        applyStimulus(0, 1'b0, 8'd0);
        checkOutput("t1_tx_ready0", 32'(n_txr[0] - b_txr[0]), 32'd3);
        checkOutput("t1_tx_ready_other", 32'(n_txr[1] + n_txr[2] + n_txr[3] - b_txr[1] - b_txr[2] - b_txr[3]), 32'd0);
        checkOutput("t1_starts", 32'(n_start - b_start), 32'd3);
        checkOutput("t1_rx_count", 32'(rx_log.size() - b_rx), 32'd3);
        checkOutput("t1_rx0", 32'(rx_log[b_rx]), 32'h1A5);
        checkOutput("t1_rx1", 32'(rx_log[b_rx+1]), 32'h13C);
        checkOutput("t1_rx2", 32'(rx_log[b_rx+2]), 32'h1FF);
        checkOutput("t1_err", 32'(last_done_err), 32'd0);
        step(3);

        $display("[TB] requesters 1 and 2 contending, len=0");
        tx_mem[1][0] = 8'h11; tx_mem[1][1] = 8'h12;
        tx_mem[2][0] = 8'h21; tx_mem[2][1] = 8'h22;
        rx_xor = 8'hFF;
        b_rx = rx_log.size(); b_done = n_done; gb = grant_log.size();
        applyStimulus(1, 1'b1, 8'd0);
        applyStimulus(2, 1'b1, 8'd0);
        waitUntil(0, b_done + 4, 200, "t2_done");
        applyStimulus(1, 1'b0, 8'd0);
        applyStimulus(2, 1'b0, 8'd0);
        checkOutput("t2_grant0", 32'(grant_log[gb]),   32'({4'b0010, 2'd1}));
        checkOutput("t2_grant1", 32'(grant_log[gb+1]), 32'({4'b0100, 2'd2}));
        checkOutput("t2_grant2", 32'(grant_log[gb+2]), 32'({4'b0010, 2'd1}));
        checkOutput("t2_grant3", 32'(grant_log[gb+3]), 32'({4'b0100, 2'd2}));
        for (int k = 1; k < 4; k++) checkOutput("t2_gap", 32'(gap_log[gb+k]), 32'd2);
        checkOutput("t2_rx0", 32'(rx_log[b_rx]),   32'h2EE);
        checkOutput("t2_rx1", 32'(rx_log[b_rx+1]), 32'h4DE);
        checkOutput("t2_rx2", 32'(rx_log[b_rx+2]), 32'h2ED);
        checkOutput("t2_rx3", 32'(rx_log[b_rx+3]), 32'h4DD);
        step(3);

        $display("[TB] stalled core, watchdog abort");
        core_mute = 1'b1;
        b_start = n_start; b_rx = rx_log.size(); b_done = n_done; b_err = n_err;
        applyStimulus(0, 1'b1, 8'd0);
        waitUntil(0, b_done + 1, 100, "t3_done");
        applyStimulus(0, 1'b0, 8'd0);
        checkOutput("t3_latency", 32'(last_done_cyc - last_start_cyc), 32'd16);
        checkOutput("t3_err", 32'(last_done_err), 32'd1);
        checkOutput("t3_err_count", 32'(n_err - b_err), 32'd1);
        checkOutput("t3_starts", 32'(n_start - b_start), 32'd1);
        checkOutput("t3_no_rx", 32'(rx_log.size() - b_rx), 32'd0);
        step(1);
        checkOutput("t3_gnt_drop", 32'(gnt_after_done), 32'h0);
        core_mute = 1'b0;
        step(3);

        $display("[TB] requester 3 drops request in LOAD");
        tx_mem[3][0] = 8'h31; tx_mem[3][1] = 8'h32;
        b_start = n_start; b_rx = rx_log.size(); b_done = n_done; b_err = n_err;
        applyStimulus(3, 1'b1, 8'd4);
        waitUntil(3, n_txr[3] + 1, 50, "t4_first_accept");
        tx_valid[3] = 1'b0;
        waitUntil(2, b_rx + 1, 50, "t4_first_rx");
        applyStimulus(3, 1'b0, 8'd0);
        waitUntil(0, b_done + 1, 50, "t4_done");
        checkOutput("t4_err", 32'(n_err - b_err), 32'd0);
        checkOutput("t4_gnt_at_done", 32'(last_done_gnt), 32'h8);
        step(10);
        checkOutput("t4_starts", 32'(n_start - b_start), 32'd1);
        checkOutput("t4_gnt_drop", 32'(gnt_after_done), 32'h0);
        tx_valid[3] = 1'b1;

        $display("[TB] reset during WAIT");
        applyStimulus(1, 1'b1, 8'd1);
        b_done = n_done;
        waitUntil(0, b_done + 1, 100, "t5_pre_done");
        applyStimulus(1, 1'b0, 8'd0);
        step(3);
        b_start = n_start;
        applyStimulus(1, 1'b1, 8'd3);
        waitUntil(1, b_start + 1, 50, "t5_start");
        b_done = n_done;
        reset = 1'b1;
        step(1);
        checkOutput("t5_state", 32'(dut.state_q), 32'(IDLE));
        checkOutput("t5_gnt", 32'({gnt, cs_sel}), 32'h0);
        checkOutput("t5_misc", 32'({tx_ready, rx_valid, burst_done, burst_err, spi_bus.spi_start}), 32'h0);
        checkOutput("t5_bytes", 32'({spi_bus.spi_tx_data, rx_data}), 32'h0);
        applyStimulus(1, 1'b0, 8'd0);
        step(1);
        reset = 1'b0;
        step(3);
        checkOutput("t5_no_done", 32'(n_done), 32'(b_done));
        gb = grant_log.size();
        applyStimulus(0, 1'b1, 8'd0);
        applyStimulus(1, 1'b1, 8'd0);
        applyStimulus(2, 1'b1, 8'd0);
        waitUntil(0, b_done + 1, 100, "t5_post_done");
        applyStimulus(0, 1'b0, 8'd0);
        applyStimulus(1, 1'b0, 8'd0);
        applyStimulus(2, 1'b0, 8'd0);
        checkOutput("t5_first_winner", 32'(grant_log[gb]), 32'({4'b0001, 2'd0}));
        step(3);

        $display("[TB] maximum length burst, len=255");
        for (int k = 0; k < 256; k++) tx_mem[2][k] = 8'(k);
        rx_xor = 8'h5A;
        b_start = n_start; b_rx = rx_log.size(); b_done = n_done; b_err = n_err;
        applyStimulus(2, 1'b1, 8'd255);
        waitUntil(0, b_done + 1, 3000, "t6_done");
        applyStimulus(2, 1'b0, 8'd0);
        checkOutput("t6_rx_count", 32'(rx_log.size() - b_rx), 32'd256);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (b_rx + k < rx_log.size()) begin
                if (rx_log[b_rx+k] !== {4'b0100, 8'(k) ^ 8'h5A}) bad++;
            end
        end
        checkOutput("t6_rx_data", 32'(bad), 32'd0);
        checkOutput("t6_err", 32'(n_err - b_err), 32'd0);
        step(10);
        checkOutput("t6_starts", 32'(n_start - b_start), 32'd256);
        checkOutput("t6_done_count", 32'(n_done - b_done), 32'd1);

        checkOutput("latency_rules", 32'(lat_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
